// File: rtl/bank_sync_requester_if.sv
// Command and sync channels between the bank-command decoder,
// the requester and the row-sync engine.
interface bank_sync_requester_if #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17
);
  localparam int NBANKS = 2 ** (BGWIDTH + BAWIDTH);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;
  logic [ADDRWIDTH-1:0] row;
  logic                 stall;
  logic [NBANKS-1:0]    sync;
  logic                 sync_wb;
  logic                 cmd_err;

  modport master (
    output cmd_valid, cmd, bg, ba, row, stall,
    input  cmd_ready, sync, sync_wb, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd, bg, ba, row, stall,
    output cmd_ready, sync, sync_wb, cmd_err
  );
endinterface

// File: rtl/bank_sync_requester.sv
// Per-bank DDR4 state tracker that issues row fetch / write-back
// sync requests to the row-sync engine.
module bank_sync_requester #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17
) (
  input  logic clk,
  input  logic reset,
  bank_sync_requester_if.slave bus,
  output logic [(2**(BGWIDTH+BAWIDTH))*5-1:0]         BankFSM,
  output logic [(2**(BGWIDTH+BAWIDTH))*ADDRWIDTH-1:0] RowId
);
  localparam int NBANKS = 2 ** (BGWIDTH + BAWIDTH);
  localparam int IW     = BGWIDTH + BAWIDTH;

  localparam logic [4:0] ST_IDLE = 5'b00000;
  localparam logic [4:0] ST_OPEN = 5'b00011;
  localparam logic [4:0] ST_RD   = 5'b01011;
  localparam logic [4:0] ST_WR   = 5'b10010;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;

  logic [4:0]           st_q  [NBANKS];
  logic [4:0]           st_n  [NBANKS];
  logic [ADDRWIDTH-1:0] row_q [NBANKS];
  logic [ADDRWIDTH-1:0] row_n [NBANKS];

  logic [NBANKS-1:0] dirty_q, dirty_n;
  logic [NBANKS-1:0] pend_q, pend_n;
  logic [NBANKS-1:0] type_q, type_n;
  logic [NBANKS-1:0] sync_q, sync_n;
  logic              wb_q, wb_n;
  logic              err_q, err_n;
  logic              accept;
  logic [IW-1:0]     idx;

  assign idx = {bus.bg, bus.ba};

  // An issued sync still counts as outstanding during its pulse
  assign bus.cmd_ready = !reset && !bus.stall
                      && (pend_q == '0) && (sync_q == '0);
  assign accept = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    st_n    = st_q;
    row_n   = row_q;
    dirty_n = dirty_q;
    pend_n  = pend_q;
    type_n  = type_q;
    err_n   = 1'b0;
    sync_n  = '0;
    wb_n    = 1'b0;

    if (accept) begin
      unique case (bus.cmd)
        CMD_NOP: begin
        end
        CMD_ACT: begin
          if (st_q[idx] == ST_IDLE) begin
            st_n[idx]    = ST_OPEN;
            row_n[idx]   = bus.row;
            dirty_n[idx] = 1'b0;
            pend_n[idx]  = 1'b1;
            type_n[idx]  = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end
        CMD_RD: begin
          if (st_q[idx] != ST_IDLE) st_n[idx] = ST_RD;
          else err_n = 1'b1;
        end
        CMD_WR: begin
          if (st_q[idx] != ST_IDLE) begin
            st_n[idx]    = ST_WR;
            dirty_n[idx] = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        CMD_PRE, CMD_PREA: begin
          for (int k = 0; k < NBANKS; k++) begin
            if ((bus.cmd == CMD_PREA || idx == IW'(k))
                && st_q[k] != ST_IDLE) begin
              st_n[k] = ST_IDLE;
              if (dirty_q[k]) begin
                pend_n[k]  = 1'b1;
                type_n[k]  = 1'b1;
                dirty_n[k] = 1'b0;
              end
            end
          end
        end
        default: err_n = 1'b1;
      endcase
    end

    // Descending scan leaves the lowest pending bank selected
    if (!bus.stall) begin
      for (int k = NBANKS - 1; k >= 0; k--) begin
        if (pend_n[k]) begin
          sync_n    = '0;
          sync_n[k] = 1'b1;
          wb_n      = type_n[k];
        end
      end
    end
    pend_n = pend_n & ~sync_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= '{default: '0};
      row_q   <= '{default: '0};
      dirty_q <= '0;
      pend_q  <= '0;
      type_q  <= '0;
      sync_q  <= '0;
      wb_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_n;
      row_q   <= row_n;
      dirty_q <= dirty_n;
      pend_q  <= pend_n;
      type_q  <= type_n;
      sync_q  <= sync_n;
      wb_q    <= wb_n;
      err_q   <= err_n;
    end
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_out
    assign BankFSM[5*g +: 5]             = st_q[g];
    assign RowId[ADDRWIDTH*g +: ADDRWIDTH] = row_q[g];
  end

  assign bus.sync    = sync_q;
  assign bus.sync_wb = wb_q;
  assign bus.cmd_err = err_q;
endmodule
